pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Program-counter stage directly downstream of the 16-bit ALU.
//   Consumes the ALU compare flag (zero) and result (out) to select the next fetch address:
//   sequential, conditional branch, absolute jump, or jump-register.
//   Drives the instruction-memory address and a one-cycle redirect pulse for fetch/decode.
//   Keeps a retired-instruction counter for debug.
// PARAMETERS
//   ADDR_W    12   PC width in bits; memory is word addressed
//   OFF_W      8   branch offset width; signed, two's complement
//   CNT_W     16   retired-instruction counter width
// PORTS
//   clk          in   1       single clock; all state updates on its rising edge
//   rst          in   1       synchronous, active-high reset
//   stall        in   1       hold PC; no retire this cycle
//   branch_eq    in   1       current instruction is a branch-if-equal
//   alu_zero     in   1       ALU zero flag; 1 = operands equal (ALU compare op 6)
//   br_offset    in   OFF_W   signed branch offset, relative to pc+1
//   jump         in   1       absolute jump
//   jump_target  in   ADDR_W  absolute jump address
//   jump_reg     in   1       jump to register value
//   alu_out      in   16      ALU result; low ADDR_W bits form the jump-register target
//   pc           out  ADDR_W  current fetch address (registered)
//   pc_plus1     out  ADDR_W  pc+1 mod 2^ADDR_W (combinational from pc)
//   redirect     out  1       registered pulse; 1 for the cycle after a non-sequential PC load
//   br_taken     out  1       combinational; branch_eq & alu_zero & ~stall
//   retired      out  CNT_W   count of non-stalled cycles since reset
// BEHAVIOUR
//   - Reset (rst=1 at edge): pc=0, redirect=0, retired=0; overrides every other input.
//     rst asserted mid-stall or mid-redirect still yields pc=0 on the next cycle.
//   - Next-PC priority, highest first:
//     rst > stall > jump_reg > jump > (branch_eq & alu_zero) > pc_plus1.
//   - stall=1: pc, retired, and all control inputs ignored; redirect cleared to 0.
//     A branch/jump presented during stall has no effect; upstream re-presents it.
//   - jump_reg: pc <= alu_out[ADDR_W-1:0]; upper alu_out bits are discarded silently.
//   - jump: pc <= jump_target.
//   - Branch taken: pc <= pc_plus1 + sext(br_offset), computed in ADDR_W bits, modulo 2^ADDR_W.
//     Negative offsets wrap below 0 to the top of the space.
//   - Branch not taken (alu_zero=0) and no other control: pc <= pc_plus1.
//   - pc = 2^ADDR_W-1 increments to 0; no error flag.
//   - redirect <= 1 only when the cycle loaded jump_reg, jump, or a taken branch; else 0.
//     Back-to-back redirects give redirect=1 on consecutive cycles.
//   - retired <= retired+1 on every non-reset, non-stall cycle; wraps at 2^CNT_W.
//   - Latency: control inputs sampled at edge N drive the new pc after edge N; redirect follows in the same cycle.
//   - Internal two-state FSM, RUN and HOLD:
//     - HOLD entered while stall=1; RUN otherwise.
//     - In HOLD, redirect is forced to 0.
//     - On the HOLD->RUN edge, pc advances normally; no extra bubble.
//   - br_taken, pc_plus1 purely combinational; no other combinational path from inputs to outputs.
// STRUCTURE
//   - Shared package cpu_pkg holds:
//     - ADDR_W default and OFF_W default
//     - next-PC select encoding: NPC_SEQ=0, NPC_BR=1, NPC_JMP=2, NPC_JR=3
//     - FSM state encoding: ST_RUN, ST_HOLD
//   - One sub-module: npc_select, combinational.
//     Takes pc_plus1, sext offset, jump_target, alu_out slice, select code.
//     Produces next_pc.
//   - The top holds the select-code priority encoder, pc/redirect/retired registers, and FSM.
// TESTING
//   1. rst=1 two cycles, then 5 free-running cycles
//      -> pc 0,1,2,3,4,5; retired=5; redirect=0 throughout.
//   2. pc=0x010, branch_eq=1, alu_zero=1, br_offset=-4 (0xFC)
//      -> pc=0x00D next cycle; redirect=1 for one cycle.
//      Same with alu_zero=0 -> pc=0x011, redirect=0.
//   3. pc=0x020, jump=1 target 0x3A0, jump_reg=1 alu_out=0xF123 same cycle
//      -> pc=0x123 (jump_reg wins, upper bits dropped).
//   4. pc=0x040, stall=1 for 3 cycles with jump=1 target 0x100
//      -> pc stays 0x040, retired frozen, redirect=0.
//      Then stall=0, jump=1 -> pc=0x100.
//   5. pc=0xFFF, no control -> pc=0x000.
//      pc=0x001, branch offset -3 -> pc=0xFFF.
//   6. Taken branch at cycle N with rst=1 at cycle N
//      -> pc=0, redirect=0, retired=0.
//      rst during HOLD -> FSM returns to RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, next-PC select codes, PC FSM states.
package cpu_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned OFF_W_DEF  = 8;
   localparam int unsigned CNT_W_DEF  = 16;
   localparam int unsigned DATA_W     = 16;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_JMP = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } pc_state_e;

endpackage

// File: rtl/pc_unit_npc_select.sv
// Next-PC datapath mux: picks the fetch address for the given select code.
module npc_select
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] pc_plus1,
   input  logic [ADDR_W-1:0] off_sext,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic [1:0]        sel,
   output logic [ADDR_W-1:0] next_pc
);

   // Branch target wraps naturally modulo 2^ADDR_W.
   always_comb begin
      next_pc = pc_plus1;
      case (npc_sel_e'(sel))
         NPC_SEQ: next_pc = pc_plus1;
         NPC_BR:  next_pc = pc_plus1 + off_sext;
         NPC_JMP: next_pc = jump_target;
         NPC_JR:  next_pc = jr_target;
         default: next_pc = pc_plus1;
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC priority, redirect pulse, retired counter and RUN/HOLD FSM.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned OFF_W  = OFF_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_eq,
   input  logic              alu_zero,
   input  logic [OFF_W-1:0]  br_offset,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              jump_reg,
   input  logic [DATA_W-1:0] alu_out,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              redirect,
   output logic              br_taken,
   output logic [CNT_W-1:0]  retired
);

   pc_state_e         state_q, state_d;
   npc_sel_e          npc_sel;
   logic              redirect_d;
   logic [ADDR_W-1:0] off_sext;
   logic [ADDR_W-1:0] next_pc;
   logic              unused_alu_hi;

   assign pc_plus1      = pc + ADDR_W'(1);
   assign br_taken      = branch_eq & alu_zero & ~stall;
   assign off_sext      = ADDR_W'($signed(br_offset));
   // Upper ALU bits are dropped on jump-register by design.
   assign unused_alu_hi = ^alu_out[DATA_W-1:ADDR_W];

   npc_select #(.ADDR_W(ADDR_W)) u_npc_select (
      .pc_plus1    (pc_plus1),
      .off_sext    (off_sext),
      .jump_target (jump_target),
      .jr_target   (alu_out[ADDR_W-1:0]),
      .sel         (npc_sel),
      .next_pc     (next_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc       <= '0;
         redirect <= 1'b0;
         retired  <= '0;
      end else begin
         state_q  <= state_d;
         redirect <= redirect_d;
         if (!stall) begin
            pc      <= next_pc;
            retired <= retired + CNT_W'(1);
         end
      end
   end

   // Select-code priority encoder, redirect decision and FSM next state.
   always_comb begin
      state_d    = state_q;
      npc_sel    = NPC_SEQ;
      redirect_d = 1'b0;
      if (!stall) begin
         if (jump_reg) begin
            npc_sel = NPC_JR;
         end else if (jump) begin
            npc_sel = NPC_JMP;
         end else if (branch_eq && alu_zero) begin
            npc_sel = NPC_BR;
         end
         redirect_d = (npc_sel != NPC_SEQ);
      end
      case (state_q)
         ST_RUN:  if (stall)  state_d = ST_HOLD;
         ST_HOLD: if (!stall) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_eq;
   logic        alu_zero;
   logic [7:0]  br_offset;
   logic        jump;
   logic [11:0] jump_target;
   logic        jump_reg;
   logic [15:0] alu_out;
   logic [11:0] pc;
   logic [11:0] pc_plus1;
   logic        redirect;
   logic        br_taken;
   logic [15:0] retired;

   int          passed;
   int          total;
   logic [15:0] exp_ret;

   pc_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch_eq   (branch_eq),
      .alu_zero    (alu_zero),
      .br_offset   (br_offset),
      .jump        (jump),
      .jump_target (jump_target),
      .jump_reg    (jump_reg),
      .alu_out     (alu_out),
      .pc          (pc),
      .pc_plus1    (pc_plus1),
      .redirect    (redirect),
      .br_taken    (br_taken),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; tracks the expected retired count from the inputs seen at the edge.
   task automatic step();
      logic r, s;
      r = rst;
      s = stall;
      @(posedge clk);
      #1;
      if (r) exp_ret = '0;
      else if (!s) exp_ret = exp_ret + 16'd1;
   endtask

   task automatic clear_ctl();
      stall = 0; branch_eq = 0; alu_zero = 0; br_offset = '0;
      jump = 0; jump_target = '0; jump_reg = 0; alu_out = '0;
   endtask

   task automatic load_pc(input logic [11:0] target);
      clear_ctl();
      jump = 1; jump_target = target;
      step();
      clear_ctl();
   endtask

   task automatic test_reset();
      rst = 1;
      clear_ctl();
      step();
      step();
      total++; if (pc !== 12'h000) $display("FAIL reset_pc got %h exp 000", pc); else passed++;
      total++; if (retired !== 16'd0) $display("FAIL reset_retired got %0d exp 0", retired); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL reset_redirect got %b exp 0", redirect); else passed++;
      rst = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         total++; if (pc !== 12'(i)) $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, 12'(i)); else passed++;
         total++; if (redirect !== 1'b0) $display("FAIL seq_redirect[%0d] got %b exp 0", i, redirect); else passed++;
      end
      total++; if (retired !== 16'd5) $display("FAIL seq_retired got %0d exp 5", retired); else passed++;
      total++; if (pc_plus1 !== 12'h006) $display("FAIL seq_pc_plus1 got %h exp 006", pc_plus1); else passed++;
   endtask

   task automatic test_branch();
      load_pc(12'h010);
      total++; if (redirect !== 1'b1) $display("FAIL jmp_redirect got %b exp 1", redirect); else passed++;
      branch_eq = 1; alu_zero = 1; br_offset = 8'hFC;
      #1;
      total++; if (br_taken !== 1'b1) $display("FAIL br_taken_comb got %b exp 1", br_taken); else passed++;
      step();
      total++; if (pc !== 12'h00D) $display("FAIL br_taken_pc got %h exp 00D", pc); else passed++;
      total++; if (redirect !== 1'b1) $display("FAIL br_taken_redirect got %b exp 1", redirect); else passed++;
      clear_ctl();
      step();
      total++; if (pc !== 12'h00E) $display("FAIL br_after_pc got %h exp 00E", pc); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL br_pulse_len got %b exp 0", redirect); else passed++;
      load_pc(12'h010);
      branch_eq = 1; alu_zero = 0; br_offset = 8'hFC;
      #1;
      total++; if (br_taken !== 1'b0) $display("FAIL br_nt_comb got %b exp 0", br_taken); else passed++;
      step();
      total++; if (pc !== 12'h011) $display("FAIL br_nt_pc got %h exp 011", pc); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL br_nt_redirect got %b exp 0", redirect); else passed++;
      clear_ctl();
   endtask

   task automatic test_jump_priority();
      load_pc(12'h020);
      jump = 1; jump_target = 12'h3A0; jump_reg = 1; alu_out = 16'hF123;
      step();
      total++; if (pc !== 12'h123) $display("FAIL jr_prio_pc got %h exp 123", pc); else passed++;
      total++; if (redirect !== 1'b1) $display("FAIL jr_prio_redirect got %b exp 1", redirect); else passed++;
      clear_ctl();
   endtask

   task automatic test_stall();
      logic [15:0] frozen;
      load_pc(12'h040);
      frozen = exp_ret;
      stall = 1; jump = 1; jump_target = 12'h100;
      #1;
      branch_eq = 1; alu_zero = 1;
      #1;
      total++; if (br_taken !== 1'b0) $display("FAIL stall_br_taken got %b exp 0", br_taken); else passed++;
      branch_eq = 0; alu_zero = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (pc !== 12'h040) $display("FAIL stall_pc[%0d] got %h exp 040", i, pc); else passed++;
         total++; if (retired !== frozen) $display("FAIL stall_retired[%0d] got %0d exp %0d", i, retired, frozen); else passed++;
         total++; if (redirect !== 1'b0) $display("FAIL stall_redirect[%0d] got %b exp 0", i, redirect); else passed++;
      end
      stall = 0;
      step();
      total++; if (pc !== 12'h100) $display("FAIL unstall_pc got %h exp 100", pc); else passed++;
      total++; if (redirect !== 1'b1) $display("FAIL unstall_redirect got %b exp 1", redirect); else passed++;
      total++; if (retired !== exp_ret) $display("FAIL unstall_retired got %0d exp %0d", retired, exp_ret); else passed++;
      clear_ctl();
   endtask

   task automatic test_wrap();
      load_pc(12'hFFF);
      total++; if (pc_plus1 !== 12'h000) $display("FAIL wrap_pc_plus1 got %h exp 000", pc_plus1); else passed++;
      step();
      total++; if (pc !== 12'h000) $display("FAIL wrap_pc got %h exp 000", pc); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL wrap_redirect got %b exp 0", redirect); else passed++;
      load_pc(12'h001);
      branch_eq = 1; alu_zero = 1; br_offset = 8'hFD;
      step();
      total++; if (pc !== 12'hFFF) $display("FAIL neg_wrap_pc got %h exp FFF", pc); else passed++;
      clear_ctl();
   endtask

   task automatic test_back_to_back();
      load_pc(12'h100);
      jump = 1; jump_target = 12'h200;
      step();
      total++; if (pc !== 12'h200) $display("FAIL b2b_pc got %h exp 200", pc); else passed++;
      total++; if (redirect !== 1'b1) $display("FAIL b2b_redirect got %b exp 1", redirect); else passed++;
      clear_ctl();
      step();
      total++; if (redirect !== 1'b0) $display("FAIL b2b_end_redirect got %b exp 0", redirect); else passed++;
      total++; if (retired !== exp_ret) $display("FAIL b2b_retired got %0d exp %0d", retired, exp_ret); else passed++;
   endtask

   task automatic test_reset_override();
      load_pc(12'h050);
      branch_eq = 1; alu_zero = 1; br_offset = 8'h10; rst = 1;
      step();
      total++; if (pc !== 12'h000) $display("FAIL rst_br_pc got %h exp 000", pc); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL rst_br_redirect got %b exp 0", redirect); else passed++;
      total++; if (retired !== 16'd0) $display("FAIL rst_br_retired got %0d exp 0", retired); else passed++;
      rst = 0;
      clear_ctl();
      load_pc(12'h070);
      stall = 1;
      step();
      rst = 1;
      step();
      total++; if (pc !== 12'h000) $display("FAIL rst_hold_pc got %h exp 000", pc); else passed++;
      rst = 0; stall = 0;
      step();
      total++; if (pc !== 12'h001) $display("FAIL rst_hold_run_pc got %h exp 001", pc); else passed++;
      total++; if (retired !== 16'd1) $display("FAIL rst_hold_retired got %0d exp 1", retired); else passed++;
      load_pc(12'h0AA);
      total++; if (pc !== 12'h0AA || redirect !== 1'b1)
         $display("FAIL rst_hold_jump got pc %h redirect %b exp 0AA 1", pc, redirect); else passed++;
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      exp_ret = '0;
      rst     = 1;
      clear_ctl();
      test_reset();
      test_branch();
      test_jump_priority();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_reset_override();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
